// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: carries the executed instruction into MEM, owns the
// architectural {Z,V,N} flag register, the sticky halt latch and the X->X forward path.
module ex_mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        EX_Valid,
    input  logic [3:0]  EX_Opcode,
    input  logic [15:0] EX_ALUOut,
    input  logic [2:0]  EX_Flag,
    input  logic [15:0] EX_StoreData,
    input  logic [3:0]  EX_DstReg,
    input  logic        EX_RegWrite,
    input  logic        EX_MemRead,
    input  logic        EX_MemWrite,
    input  logic        EX_Halt,
    output logic        MEM_Valid,
    output logic        MEM_RegWrite,
    output logic        MEM_MemRead,
    output logic        MEM_MemWrite,
    output logic        MEM_Halt,
    output logic [3:0]  MEM_Opcode,
    output logic [15:0] MEM_ALUOut,
    output logic [15:0] MEM_StoreData,
    output logic [3:0]  MEM_DstReg,
    output logic [2:0]  FlagReg,
    output logic        XtoXforward_En,
    output logic [15:0] XtoXforward_Data,
    output logic        Halted
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;

    logic        valid_q, valid_d;
    logic        regwrite_q, regwrite_d;
    logic        memread_q, memread_d;
    logic        memwrite_q, memwrite_d;
    logic        halt_q, halt_d;
    logic [3:0]  opcode_q, opcode_d;
    logic [15:0] aluout_q, aluout_d;
    logic [15:0] storedata_q, storedata_d;
    logic [3:0]  dstreg_q, dstreg_d;
    logic [2:0]  flag_q, flag_d;
    logic        halted_q, halted_d;

    logic load_real;

    // Once halted, every further EX instruction is squashed into a bubble.
    assign load_real = EX_Valid && !halted_q;

    always_comb begin
        valid_d     = valid_q;
        regwrite_d  = regwrite_q;
        memread_d   = memread_q;
        memwrite_d  = memwrite_q;
        halt_d      = halt_q;
        opcode_d    = opcode_q;
        aluout_d    = aluout_q;
        storedata_d = storedata_q;
        dstreg_d    = dstreg_q;
        flag_d      = flag_q;
        halted_d    = halted_q;

        if (flush) begin
            valid_d     = 1'b0;
            regwrite_d  = 1'b0;
            memread_d   = 1'b0;
            memwrite_d  = 1'b0;
            halt_d      = 1'b0;
            opcode_d    = 4'd0;
            aluout_d    = 16'd0;
            storedata_d = 16'd0;
            dstreg_d    = 4'd0;
        end else if (!stall) begin
            if (load_real) begin
                valid_d     = 1'b1;
                regwrite_d  = EX_RegWrite;
                memread_d   = EX_MemRead;
                memwrite_d  = EX_MemWrite;
                halt_d      = EX_Halt;
                opcode_d    = EX_Opcode;
                aluout_d    = EX_ALUOut;
                storedata_d = EX_StoreData;
                dstreg_d    = EX_DstReg;
                if (EX_Halt) begin
                    halted_d = 1'b1;
                end
                case (EX_Opcode)
                    OP_ADD, OP_SUB:                 flag_d    = EX_Flag;
                    OP_XOR, OP_SLL, OP_SRA, OP_ROR: flag_d[2] = EX_Flag[2];
                    default:                        flag_d    = flag_q;
                endcase
            end else begin
                valid_d     = 1'b0;
                regwrite_d  = 1'b0;
                memread_d   = 1'b0;
                memwrite_d  = 1'b0;
                halt_d      = 1'b0;
                opcode_d    = 4'd0;
                aluout_d    = 16'd0;
                storedata_d = 16'd0;
                dstreg_d    = 4'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            regwrite_q  <= 1'b0;
            memread_q   <= 1'b0;
            memwrite_q  <= 1'b0;
            halt_q      <= 1'b0;
            opcode_q    <= 4'd0;
            aluout_q    <= 16'd0;
            storedata_q <= 16'd0;
            dstreg_q    <= 4'd0;
            flag_q      <= 3'b000;
            halted_q    <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            regwrite_q  <= regwrite_d;
            memread_q   <= memread_d;
            memwrite_q  <= memwrite_d;
            halt_q      <= halt_d;
            opcode_q    <= opcode_d;
            aluout_q    <= aluout_d;
            storedata_q <= storedata_d;
            dstreg_q    <= dstreg_d;
            flag_q      <= flag_d;
            halted_q    <= halted_d;
        end
    end

    assign MEM_Valid     = valid_q;
    assign MEM_RegWrite  = regwrite_q;
    assign MEM_MemRead   = memread_q;
    assign MEM_MemWrite  = memwrite_q;
    assign MEM_Halt      = halt_q;
    assign MEM_Opcode    = opcode_q;
    assign MEM_ALUOut    = aluout_q;
    assign MEM_StoreData = storedata_q;
    assign MEM_DstReg    = dstreg_q;
    assign FlagReg       = flag_q;
    assign Halted        = halted_q;

    // Load results are not available until after MEM, so loads never forward from here.
    assign XtoXforward_En   = valid_q && regwrite_q && (dstreg_q != 4'd0) && !memread_q;
    assign XtoXforward_Data = aluout_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios plus randomized traffic scored
// against a per-cycle behavioural model of the MEM-stage contents.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic        EX_Valid;
    logic [3:0]  EX_Opcode;
    logic [15:0] EX_ALUOut;
    logic [2:0]  EX_Flag;
    logic [15:0] EX_StoreData;
    logic [3:0]  EX_DstReg;
    logic        EX_RegWrite, EX_MemRead, EX_MemWrite, EX_Halt;
    logic        MEM_Valid, MEM_RegWrite, MEM_MemRead, MEM_MemWrite, MEM_Halt;
    logic [3:0]  MEM_Opcode;
    logic [15:0] MEM_ALUOut;
    logic [15:0] MEM_StoreData;
    logic [3:0]  MEM_DstReg;
    logic [2:0]  FlagReg;
    logic        XtoXforward_En;
    logic [15:0] XtoXforward_Data;
    logic        Halted;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .EX_Valid(EX_Valid), .EX_Opcode(EX_Opcode), .EX_ALUOut(EX_ALUOut),
        .EX_Flag(EX_Flag), .EX_StoreData(EX_StoreData), .EX_DstReg(EX_DstReg),
        .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
        .EX_MemWrite(EX_MemWrite), .EX_Halt(EX_Halt),
        .MEM_Valid(MEM_Valid), .MEM_RegWrite(MEM_RegWrite),
        .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
        .MEM_Halt(MEM_Halt), .MEM_Opcode(MEM_Opcode), .MEM_ALUOut(MEM_ALUOut),
        .MEM_StoreData(MEM_StoreData), .MEM_DstReg(MEM_DstReg),
        .FlagReg(FlagReg), .XtoXforward_En(XtoXforward_En),
        .XtoXforward_Data(XtoXforward_Data), .Halted(Halted)
    );

    typedef struct {
        bit          valid, rw, mr, mw, hlt;
        bit  [3:0]   op;
        bit  [15:0]  alu, sd;
        bit  [3:0]   dst;
        bit  [2:0]   flag;
        bit          halted;
        bit          known;   // data fields are defined (not a don't-care bubble)
    } model_t;

    model_t m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input bit [3:0] op, input bit [15:0] alu,
                         input bit [2:0] fl, input bit [15:0] sd, input bit [3:0] dst,
                         input bit rw, input bit mr, input bit mw, input bit hl);
        EX_Valid = v; EX_Opcode = op; EX_ALUOut = alu; EX_Flag = fl;
        EX_StoreData = sd; EX_DstReg = dst; EX_RegWrite = rw;
        EX_MemRead = mr; EX_MemWrite = mw; EX_Halt = hl;
    endtask

    task automatic clear_stage();
        m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.hlt = 0;
        m.op = 0; m.alu = 0; m.sd = 0; m.dst = 0; m.known = 1;
    endtask

    // What MEM should hold after this edge, derived from the architectural rules.
    task automatic model_edge();
        if (rst) begin
            clear_stage();
            m.flag = 3'b000;
            m.halted = 0;
        end else if (flush) begin
            clear_stage();
        end else if (stall) begin
            // nothing moves
        end else if (EX_Valid && !m.halted) begin
            m.valid = 1; m.rw = EX_RegWrite; m.mr = EX_MemRead; m.mw = EX_MemWrite;
            m.hlt = EX_Halt; m.op = EX_Opcode; m.alu = EX_ALUOut; m.sd = EX_StoreData;
            m.dst = EX_DstReg; m.known = 1;
            if (EX_Opcode <= 4'd1)
                m.flag = EX_Flag;
            else if (EX_Opcode == 4'd2 || EX_Opcode == 4'd4 || EX_Opcode == 4'd5 || EX_Opcode == 4'd6)
                m.flag = {EX_Flag[2], m.flag[1:0]};
            if (EX_Halt) m.halted = 1;
        end else begin
            m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.hlt = 0; m.known = 0;
        end
    endtask

    task automatic compare_all();
        bit fwd;
        fwd = m.valid && m.rw && (m.dst != 0) && !m.mr;
        chk("MEM_Valid", MEM_Valid, m.valid);
        chk("MEM_RegWrite", MEM_RegWrite, m.rw);
        chk("MEM_MemRead", MEM_MemRead, m.mr);
        chk("MEM_MemWrite", MEM_MemWrite, m.mw);
        chk("MEM_Halt", MEM_Halt, m.hlt);
        chk("FlagReg", FlagReg, m.flag);
        chk("Halted", Halted, m.halted);
        chk("XtoX_En", XtoXforward_En, fwd);
        if (m.known) begin
            chk("MEM_Opcode", MEM_Opcode, m.op);
            chk("MEM_ALUOut", MEM_ALUOut, m.alu);
            chk("MEM_StoreData", MEM_StoreData, m.sd);
            chk("MEM_DstReg", MEM_DstReg, m.dst);
            chk("XtoX_Data", XtoXforward_Data, m.alu);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        m = '{default: 0};
        rst = 1; stall = 0; flush = 0;
        drive(1, 4'd0, 16'hFFFF, 3'b111, 16'hFFFF, 4'd7, 1, 0, 0, 0);
        step();
        chk("rst_flag", FlagReg, 3'b000);
        chk("rst_halted", Halted, 1'b0);
        chk("rst_fwd", XtoXforward_En, 1'b0);
        rst = 0;

        // ADD with forwarding
        drive(1, 4'd0, 16'h1234, 3'b011, 16'h0, 4'd5, 1, 0, 0, 0);
        step();
        chk("add_alu", MEM_ALUOut, 16'h1234);
        chk("add_flag", FlagReg, 3'b011);
        chk("add_fwd", XtoXforward_En, 1'b1);
        chk("add_fwdd", XtoXforward_Data, 16'h1234);

        // XOR writes Z only, load leaves flags alone and does not forward
        drive(1, 4'd2, 16'h0, 3'b100, 16'h0, 4'd6, 1, 0, 0, 0);
        step();
        chk("xor_flag", FlagReg, 3'b111);
        drive(1, 4'd8, 16'h0040, 3'b000, 16'h0, 4'd6, 1, 1, 0, 0);
        step();
        chk("lw_flag", FlagReg, 3'b111);
        chk("lw_fwd", XtoXforward_En, 1'b0);
        chk("lw_addr", MEM_ALUOut, 16'h0040);

        // SUB then 3-cycle stall with changing EX inputs
        drive(1, 4'd1, 16'h0BEE, 3'b101, 16'h5555, 4'd3, 1, 0, 0, 0);
        step();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'd0, 16'($urandom), 3'($urandom), 16'($urandom), 4'd9, 1, 0, 1, 0);
            step();
            chk("stall_alu", MEM_ALUOut, 16'h0BEE);
            chk("stall_dst", MEM_DstReg, 4'd3);
            chk("stall_flag", FlagReg, 3'b101);
        end

        // flush wins over stall
        flush = 1;
        drive(1, 4'd0, 16'h7777, 3'b010, 16'h0, 4'd2, 1, 0, 0, 0);
        step();
        chk("fl_valid", MEM_Valid, 1'b0);
        chk("fl_rw", MEM_RegWrite, 1'b0);
        chk("fl_flag", FlagReg, 3'b101);
        flush = 0; stall = 0;

        // halt is sticky and squashes later instructions
        drive(1, 4'd15, 16'h0, 3'b000, 16'h0, 4'd0, 0, 0, 0, 1);
        step();
        chk("hlt_halted", Halted, 1'b1);
        chk("hlt_memhalt", MEM_Halt, 1'b1);
        drive(1, 4'd0, 16'h1111, 3'b010, 16'h0, 4'd4, 1, 0, 0, 0);
        step();
        chk("post_hlt_valid", MEM_Valid, 1'b0);
        chk("post_hlt_flag", FlagReg, 3'b101);
        rst = 1;
        step();
        chk("rst_unhalt", Halted, 1'b0);
        rst = 0;

        // r0 destination: register write kept, no forward
        drive(1, 4'd0, 16'h4321, 3'b000, 16'h0, 4'd0, 1, 0, 0, 0);
        step();
        chk("r0_rw", MEM_RegWrite, 1'b1);
        chk("r0_fwd", XtoXforward_En, 1'b0);

        // reset during stall and flush
        stall = 1; rst = 1;
        step();
        chk("rst_stall_alu", MEM_ALUOut, 16'h0);
        stall = 0; flush = 1;
        step();
        flush = 0; rst = 0;

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(99) < 3);
            flush = ($urandom_range(99) < 8);
            stall = ($urandom_range(99) < 15);
            drive($urandom_range(99) < 80, 4'($urandom), 16'($urandom), 3'($urandom),
                  16'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), $urandom_range(99) < 2);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: stall  in  1  hold all state this cycle.
REQ-004 SHALL have: flush  in  1  load a bubble this cycle.
REQ-005 SHALL have: EX_Valid  in  1  EX holds a real instruction.
REQ-006 SHALL have: EX_Opcode  in  4  EX opcode.
REQ-007 SHALL have: EX_ALUOut  in  16  ALU result.
REQ-008 SHALL have: EX_Flag  in  3  ALU flags {Z,V,N}.
REQ-009 SHALL have: EX_StoreData  in  16  forwarded second read operand.
REQ-010 SHALL have: EX_DstReg  in  4  destination register.
REQ-011 SHALL have: EX_RegWrite, EX_MemRead, EX_MemWrite, EX_Halt  in  1 each  control bits.
REQ-012 SHALL have: MEM_Valid, MEM_RegWrite, MEM_MemRead, MEM_MemWrite, MEM_Halt  out  1 each  registered copies.
REQ-013 SHALL have: MEM_Opcode  out  4; MEM_ALUOut  out  16; MEM_StoreData  out  16; MEM_DstReg  out  4.
REQ-014 SHALL have: FlagReg  out  3  architectural {Z,V,N} used by branch resolution.
REQ-015 SHALL have: XtoXforward_En  out  1  asserted when MEM_Valid & MEM_RegWrite & MEM_DstReg != 0 & !MEM_MemRead.
REQ-016 SHALL have: XtoXforward_Data  out  16  equal to MEM_ALUOut.
REQ-017 SHALL have: Halted  out  1  sticky: a halt has reached MEM.

Function
REQ-018 Priority per edge SHALL be rst > flush > stall > normal load.
REQ-019 Normal load (no rst/flush/stall) SHALL copy every EX_* field to its MEM_* register, latency exactly one cycle.
REQ-020 On load with EX_Valid=0, MEM_Valid SHALL be 0 and MEM_RegWrite/MemRead/MemWrite/Halt SHALL be 0; data fields are don't-care.
REQ-021 Stall SHALL hold every MEM_* register, FlagReg and Halted unchanged.
REQ-022 Flush SHALL load a bubble: MEM_Valid and all MEM_ control bits 0, MEM_Opcode 0, data fields 0; flush with stall SHALL still load the bubble.
REQ-023 FlagReg SHALL update only on a normal load with EX_Valid=1.
REQ-024 Opcodes 0000 (ADD), 0001 (SUB) SHALL write all of Z,V,N from EX_Flag.
REQ-025 Opcodes 0010 (XOR), 0100 (SLL), 0101 (SRA), 0110 (ROR) SHALL write Z only; V,N hold.
REQ-026 All other opcodes SHALL leave FlagReg unchanged.
REQ-027 FlagReg SHALL reflect the updating instruction's flags in the cycle after its load, i.e. with that instruction in MEM.
REQ-028 Halted SHALL set on a normal load with EX_Valid=1 and EX_Halt=1 and stay set until rst.
REQ-029 Once Halted=1, subsequent normal loads SHALL be forced to bubbles (no further architectural effect).
REQ-030 XtoXforward_En SHALL be purely combinational from MEM registers; no extra latency.
REQ-031 Load-type MEM_ALUOut SHALL carry the computed address; forwarding of load data is outside this block.

Reset
REQ-032 With rst=1 at an edge, all outputs SHALL be 0 the following cycle: MEM_* 0, FlagReg 3'b000, Halted 0, XtoXforward_En 0.
REQ-033 rst asserted mid-stall or mid-flush SHALL give the same reset state; no residue of prior contents.
REQ-034 First normal load after rst deassertion SHALL behave per REQ-019.

Verification
REQ-035 ADD valid, EX_ALUOut=16'h1234, EX_Flag=3'b011, DstReg=5, RegWrite=1 -> next cycle MEM_ALUOut=16'h1234, FlagReg=3'b011, XtoXforward_En=1, XtoXforward_Data=16'h1234.
REQ-036 FlagReg=3'b011, then XOR valid with EX_Flag=3'b100 -> FlagReg=3'b111; then LW valid with EX_Flag=3'b000 -> FlagReg stays 3'b111, XtoXforward_En=0.
REQ-037 MEM holds SUB DstReg=3, stall=1 for 3 cycles with new EX inputs -> all MEM_* and FlagReg unchanged across all 3 cycles.
REQ-038 stall=1 and flush=1 same edge with valid ADD at EX -> MEM_Valid=0, MEM_RegWrite=0, FlagReg unchanged.
REQ-039 Valid HLT loaded -> Halted=1, MEM_Halt=1; next valid ADD with RegWrite -> MEM_Valid=0, FlagReg unchanged; rst -> Halted=0.
REQ-040 ADD valid with DstReg=0, RegWrite=1 -> MEM_RegWrite=1, XtoXforward_En=0.
